pong_match_ctrl: RTL
====================

# pong_match_ctrl

Match-level sequencer for the Pong datapath. It owns the 2-bit `game_state` bus that gates ball motion and scoring, debounces the start and pause buttons, and inserts the serve countdown and post-point pause. It watches both score counters to detect points and a match win, and issues the synchronous clear that restarts the ball/score block for a new match. It sits between the board buttons and the ball and paddle logic, in the `clk_1ms` domain.

## Interface
- `DEBOUNCE_MS`, 20: cycles a synchronised button level must stay stable before it is accepted.
- `SERVE_DELAY_MS`, 1000: cycles spent in SERVE before the ball is released.
- `POINT_PAUSE_MS`, 1500: cycles the ball is frozen after a point.
- `WIN_SCORE`, 7: score that ends the match (1..15).
- `clk_1ms` in 1: 1 kHz game tick.
- `reset` in 1: reset, synchronous, active-low; clock clk_1ms.
- `start_btn` in 1: raw, asynchronous, active-high start button.
- `pause_btn` in 1: raw, asynchronous, active-high pause button.
- `p1_score` in 4: player-1 score from the ball block.
- `p2_score` in 4: player-2 score from the ball block.
- `game_state` out 2: 00 held, 01 play (ball moves), 10 frozen (pause or point), 11 game over.
- `winner` out 2: 00 none, 01 player 1, 10 player 2.
- `serving` out 1: high while in SERVE.
- `ball_rst_n` out 1: active-low synchronous clear to the ball block.

## Operation
- **Button path (each button):**
  - 2-flop synchroniser, then a stability counter; the accepted level changes after `DEBOUNCE_MS` consecutive equal samples.
  - A rising edge of the accepted level produces a 1-cycle press pulse.
- **FSM states and `game_state`:** IDLE(00), SERVE(00), PLAY(01), POINT(10), PAUSE(10), OVER(11).
- **Transitions:**
  - IDLE: start press → SERVE.
  - SERVE: timer expiry → PLAY.
  - PLAY, no score change:
    - pause press → PAUSE.
  - PLAY, score change:
    - If the changed score is `>= WIN_SCORE`, go to OVER and set `winner`.
    - Otherwise go to POINT.
  - POINT: timer expiry → SERVE.
  - PAUSE: pause press → PLAY, with no countdown.
  - OVER: start press → IDLE and clear the match.
- **Ignored presses:** start is ignored in SERVE, PLAY, POINT and PAUSE. Pause is ignored outside PLAY and PAUSE.
- **Score-change detect:** `p1_prev` and `p2_prev` register the inputs every cycle. A change means input ≠ prev, evaluated in PLAY only.
- **Simultaneous events:**
  - Score change and pause press in the same cycle: the score change wins and the pause press is dropped.
  - Both scores change in the same cycle: player 1 is evaluated first. If both reach `WIN_SCORE`, `winner` = 01.
- **Timer:**
  - One shared 16-bit down-counter.
  - Loaded with `delay-1` on entry to SERVE or POINT.
  - Expiry occurs when the count is 0 in that state.
  - Held at 0 in all other states.
  - The parameters must be `<= 65535`; the bench asserts this.
- **Match clear:** `ball_rst_n` = `reset` AND NOT(`clr_pulse`). `clr_pulse` is a registered 1-cycle pulse issued on the OVER→IDLE transition; it zeroes the scores and recentres the ball.
- **Winner:** `winner` is cleared on the OVER→IDLE transition.

## Timing
- **Reset values** (while `reset` = 0, applied at the clock edge):
  - State IDLE, `game_state` 00, `winner` 00, `serving` 0.
  - Timer 0, prev scores 0.
  - Debouncers accept level 0 with no pulse.
  - `ball_rst_n` = 0 combinationally.
- **Reset mid-operation:** any state returns to IDLE on the next edge; no pending press survives.
- **Button latency:** a clean raw rising edge produces a press pulse `2 + DEBOUNCE_MS` cycles later. The state changes on the following edge, and outputs are registered.
- **Durations:** SERVE lasts exactly `SERVE_DELAY_MS` cycles. POINT lasts exactly `POINT_PAUSE_MS` cycles.
- **Point detect:** a score updated at edge N moves the FSM at edge N+1. The ball therefore sees `game_state` = 01 at edge N+1 and advances once more; this overrun is accepted.
- **Clear pulse:** `ball_rst_n` is low for exactly 1 cycle, in the first cycle of IDLE after OVER.

## Structure
- **Package `pong_pkg`:**
  - `game_state` encodings GS_HELD, GS_PLAY, GS_FROZEN, GS_OVER.
  - Winner encodings.
  - FSM state enum.
  - `H_ACTIVE`/`V_ACTIVE` constants, which are shared with the ball and paddle blocks.
- **Sub-module `btn_debounce`:**
  - Synchroniser, stability counter and edge pulse.
  - Parameter `DEBOUNCE_MS`.
  - Instantiated twice.

## Test plan
Parameters for all scenarios: `DEBOUNCE_MS`=4, `SERVE_DELAY_MS`=10, `POINT_PAUSE_MS`=5, `WIN_SCORE`=3.
- **Start/serve:** start held 20 cycles from IDLE → pulse 6 cycles after the edge, `serving`=1 for 10 cycles, then `game_state`=01.
- **Bounce rejection:** start toggling every 2 cycles for 30 cycles, then low → no state change.
- **Point:** in PLAY, `p2_score` 0→1 → `game_state`=10 for 5 cycles, then SERVE for 10 cycles, then 01.
- **Win:** in PLAY, `p1_score` 2→3 → `game_state`=11 and `winner`=01. Start press → IDLE, `ball_rst_n` low exactly 1 cycle, `winner`=00.
- **Pause collision:** pause press in PLAY the same cycle `p2_score` changes → POINT, not PAUSE. A later pause press in PLAY → 10, and a second press → 01.
- **Reset:** `reset` low for 1 cycle during SERVE at timer 4 → IDLE, `game_state`=00, `serving`=0, timer 0; `ball_rst_n` low that cycle.

Source files
------------

// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared encodings and constants for the pong match sequencer
package pong_pkg;

  // game_state bus encodings seen by the ball and paddle blocks
  localparam logic [1:0] GS_HELD   = 2'b00;
  localparam logic [1:0] GS_PLAY   = 2'b01;
  localparam logic [1:0] GS_FROZEN = 2'b10;
  localparam logic [1:0] GS_OVER   = 2'b11;

  // winner encodings
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  // visible raster size, shared with the ball and paddle blocks
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  // match sequencer states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SERVE,
    ST_PLAY,
    ST_POINT,
    ST_PAUSE,
    ST_OVER
  } match_state_t;

endpackage

// File: rtl/pong_match_ctrl_if.sv
// rtl/pong_match_ctrl_if.sv - score inputs and match-state outputs between sequencer and ball block
interface pong_match_ctrl_if;
  import pong_pkg::*;

  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic [1:0] game_state;
  logic [1:0] winner;
  logic       serving;
  logic       ball_rst_n;

  // sequencer side: watches scores, drives match state
  modport master (
    input  p1_score,
    input  p2_score,
    output game_state,
    output winner,
    output serving,
    output ball_rst_n
  );

  // ball block side: drives scores, obeys match state
  modport slave (
    output p1_score,
    output p2_score,
    input  game_state,
    input  winner,
    input  serving,
    input  ball_rst_n
  );

endinterface

// File: rtl/pong_match_ctrl_btn_debounce.sv
// rtl/pong_match_ctrl_btn_debounce.sv - button synchroniser, stability filter and press pulse
module btn_debounce #(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk_1ms,
  input  logic reset,
  input  logic btn,
  output logic press
);
  import pong_pkg::*;

  localparam int CW = $clog2(DEBOUNCE_MS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_MS - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // two-flop synchroniser for the raw asynchronous button
  always_ff @(posedge clk_1ms) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // count consecutive samples that disagree with the accepted level; flip after DEBOUNCE_MS
  always_ff @(posedge clk_1ms) begin
    if (!reset) begin
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync2;
          cnt   <= '0;
          press <= sync2;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/pong_match_ctrl.sv
// rtl/pong_match_ctrl.sv - match sequencer: serve countdown, point pause, pause, win and match clear
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int DEBOUNCE_MS    = 20,
  parameter int SERVE_DELAY_MS = 1000,
  parameter int POINT_PAUSE_MS = 1500,
  parameter int WIN_SCORE      = 7
) (
  input  logic clk_1ms,
  input  logic reset,
  input  logic start_btn,
  input  logic pause_btn,
  pong_match_ctrl_if.master bus
);

  localparam logic [15:0] SERVE_LOAD = 16'(SERVE_DELAY_MS - 1);
  localparam logic [15:0] POINT_LOAD = 16'(POINT_PAUSE_MS - 1);
  localparam logic [3:0]  WIN_VAL    = 4'(WIN_SCORE);

  match_state_t state;
  logic [15:0]  timer;
  logic [3:0]   p1_prev;
  logic [3:0]   p2_prev;
  logic [1:0]   game_state;
  logic [1:0]   winner;
  logic         serving;
  logic         clr_pulse;
  logic         start_press;
  logic         pause_press;
  logic         p1_hit;
  logic         p2_hit;
  logic         p1_win;
  logic         p2_win;

  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_start_db (
    .clk_1ms (clk_1ms),
    .reset   (reset),
    .btn     (start_btn),
    .press   (start_press)
  );

  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_pause_db (
    .clk_1ms (clk_1ms),
    .reset   (reset),
    .btn     (pause_btn),
    .press   (pause_press)
  );

  // a point is any score that differs from last cycle's sample; it wins if it reaches WIN_SCORE
  always_comb begin
    p1_hit = (bus.p1_score != p1_prev);
    p2_hit = (bus.p2_score != p2_prev);
    p1_win = p1_hit && (bus.p1_score >= WIN_VAL);
    p2_win = p2_hit && (bus.p2_score >= WIN_VAL);
  end

  // remember last cycle's scores for change detection
  always_ff @(posedge clk_1ms) begin
    if (!reset) begin
      p1_prev <= 4'd0;
      p2_prev <= 4'd0;
    end else begin
      p1_prev <= bus.p1_score;
      p2_prev <= bus.p2_score;
    end
  end

  // match FSM with the shared countdown and registered outputs; scoring beats pause, p1 beats p2
  always_ff @(posedge clk_1ms) begin
    if (!reset) begin
      state      <= ST_IDLE;
      game_state <= GS_HELD;
      winner     <= WIN_NONE;
      serving    <= 1'b0;
      timer      <= 16'd0;
      clr_pulse  <= 1'b0;
    end else begin
      clr_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_press) begin
            state   <= ST_SERVE;
            serving <= 1'b1;
            timer   <= SERVE_LOAD;
          end
        end
        ST_SERVE: begin
          if (timer == 16'd0) begin
            state      <= ST_PLAY;
            game_state <= GS_PLAY;
            serving    <= 1'b0;
          end else begin
            timer <= timer - 16'd1;
          end
        end
        ST_PLAY: begin
          if (p1_win) begin
            state      <= ST_OVER;
            game_state <= GS_OVER;
            winner     <= WIN_P1;
          end else if (p2_win) begin
            state      <= ST_OVER;
            game_state <= GS_OVER;
            winner     <= WIN_P2;
          end else if (p1_hit || p2_hit) begin
            state      <= ST_POINT;
            game_state <= GS_FROZEN;
            timer      <= POINT_LOAD;
          end else if (pause_press) begin
            state      <= ST_PAUSE;
            game_state <= GS_FROZEN;
          end
        end
        ST_POINT: begin
          if (timer == 16'd0) begin
            state      <= ST_SERVE;
            game_state <= GS_HELD;
            serving    <= 1'b1;
            timer      <= SERVE_LOAD;
          end else begin
            timer <= timer - 16'd1;
          end
        end
        ST_PAUSE: begin
          if (pause_press) begin
            state      <= ST_PLAY;
            game_state <= GS_PLAY;
          end
        end
        ST_OVER: begin
          if (start_press) begin
            state      <= ST_IDLE;
            game_state <= GS_HELD;
            winner     <= WIN_NONE;
            clr_pulse  <= 1'b1;
          end
        end
        default: begin
          state      <= ST_IDLE;
          game_state <= GS_HELD;
          winner     <= WIN_NONE;
          serving    <= 1'b0;
          timer      <= 16'd0;
        end
      endcase
    end
  end

  assign bus.game_state = game_state;
  assign bus.winner     = winner;
  assign bus.serving    = serving;
  // ball block clear: system reset or the one-cycle new-match pulse
  assign bus.ball_rst_n = reset & ~clr_pulse;

endmodule
